// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between eight requesters and the round-robin arbiter.
// master = requester side (drives req/done), slave = arbiter side.
interface rr_arbiter8_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] gnt_idx;
  logic       busy;
  logic       timeout;

  modport master (
    output req,
    output done,
    input  grant,
    input  gnt_idx,
    input  busy,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output grant,
    output gnt_idx,
    output busy,
    output timeout
  );
endinterface

// File: rtl/rr_arbiter8.sv
// 8-way round-robin arbiter, grant registered one cycle after req; holds until done/req drop, always one idle cycle between grants.
// Optional forced release after MAX_HOLD cycles when RR_ARBITER8_TIMEOUT_EN is defined.
module rr_arbiter8 #(
  parameter int MAX_HOLD = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  rr_arbiter8_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] grant_q, grant_d;

  logic [2:0] pick_idx;
  logic [2:0] cand;
  logic       found;

`ifdef RR_ARBITER8_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;
`else
  wire [7:0] unused_hold_last = HOLD_LAST;
`endif

  // First requester at or after ptr, wrapping modulo 8.
  always_comb begin
    pick_idx = ptr_q;
    cand     = ptr_q;
    found    = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cand = ptr_q + 3'(k);
      if (!found && bus.req[cand]) begin
        pick_idx = cand;
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    grant_d = grant_q;
`ifdef RR_ARBITER8_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        grant_d = 8'h00;
        if (|bus.req) begin
          state_d = GRANT;
          idx_d   = pick_idx;
          grant_d = 8'h01 << pick_idx;
`ifdef RR_ARBITER8_TIMEOUT_EN
          cnt_d   = 8'h00;
`endif
        end
      end
      GRANT: begin
        // done wins over an expiring hold so that case is a normal release.
        if (bus.done || !bus.req[idx_q]) begin
          state_d = IDLE;
          grant_d = 8'h00;
          ptr_d   = idx_q + 3'd1;
        end
`ifdef RR_ARBITER8_TIMEOUT_EN
        if (!bus.done && cnt_q == HOLD_LAST) begin
          state_d   = IDLE;
          grant_d   = 8'h00;
          ptr_d     = idx_q + 3'd1;
          timeout_d = 1'b1;
        end
        cnt_d = cnt_q + 8'd1;
`endif
      end
      default: begin
        state_d = IDLE;
        grant_d = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 3'd0;
      idx_q   <= 3'd0;
      grant_q <= 8'h00;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      grant_q <= grant_d;
    end
  end

`ifdef RR_ARBITER8_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= 8'h00;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.grant   = grant_q;
  assign bus.gnt_idx = idx_q;
  assign bus.busy    = (state_q == GRANT);

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8 with a cycle-level reference model compared every negedge.
module tb_rr_arbiter8;
`ifdef RR_ARBITER8_TIMEOUT_EN
  localparam int  MH    = 4;
  localparam bit  TO_EN = 1'b1;
`else
  localparam int  MH    = 15;
  localparam bit  TO_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  rr_arbiter8_if bus ();

  rr_arbiter8 #(.MAX_HOLD(MH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: who holds the resource, where the search starts next.
  bit m_busy;
  int m_idx;
  int m_ptr;
  int m_held;
  bit m_to;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_idx = 0; m_ptr = 0; m_held = 0; m_to = 0;
    end else begin
      m_to = 0;
      if (!m_busy) begin
        if (bus.req != 8'h00) begin
          for (int k = 7; k >= 0; k--)
            if (bus.req[(m_ptr + k) % 8]) m_idx = (m_ptr + k) % 8;
          m_busy = 1;
          m_held = 1;
        end
      end else if (bus.done) begin
        m_busy = 0; m_ptr = (m_idx + 1) % 8;
      end else if (TO_EN && m_held == MH) begin
        m_busy = 0; m_ptr = (m_idx + 1) % 8; m_to = 1;
      end else if (!bus.req[m_idx]) begin
        m_busy = 0; m_ptr = (m_idx + 1) % 8;
      end else begin
        m_held = m_held + 1;
      end
    end
  end

  always @(negedge clk) begin
    logic [7:0] exp_g;
    exp_g = m_busy ? (8'h01 << m_idx) : 8'h00;
    checks++;
    if (bus.grant !== exp_g || bus.gnt_idx !== 3'(m_idx) ||
        bus.busy !== m_busy || bus.timeout !== m_to ||
        $countones(bus.grant) > 1) begin
      errors++;
      $display("FAIL model t=%0t grant=%h idx=%0d busy=%b to=%b required grant=%h idx=%0d busy=%b to=%b",
               $time, bus.grant, bus.gnt_idx, bus.busy, bus.timeout, exp_g, m_idx, m_busy, m_to);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [7:0] g, input logic b, input logic to);
    checks++;
    if (bus.grant !== g || bus.busy !== b || bus.timeout !== to) begin
      errors++;
      $display("FAIL %s grant=%h busy=%b timeout=%b required grant=%h busy=%b timeout=%b",
               name, bus.grant, bus.busy, bus.timeout, g, b, to);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req = 8'h00;
    bus.done = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.req = 8'h00;
    bus.done = 1'b0;
    #1;
    chk("reset_state", 8'h00, 1'b0, 1'b0);
    checks++;
    if (bus.gnt_idx !== 3'd0) begin
      errors++;
      $display("FAIL reset_idx gnt_idx=%0d required 0", bus.gnt_idx);
    end
    do_reset();

    // Single requester, then done.
    bus.req = 8'h01;
    tick();
    chk("single_grant", 8'h01, 1'b1, 1'b0);
    bus.done = 1'b1;
    tick();
    chk("single_release", 8'h00, 1'b0, 1'b0);
    bus.done = 1'b0;
    bus.req = 8'h00;
    tick();

    // done in IDLE is ignored and gnt_idx sticks at the last grantee.
    bus.req = 8'h00;
    bus.done = 1'b1;
    tick();
    chk("done_idle", 8'h00, 1'b0, 1'b0);
    bus.done = 1'b0;

    // All requesting with done held: rotation with one idle gap, wrapping 7->0.
    do_reset();
    bus.req = 8'hFF;
    bus.done = 1'b1;
    for (int g = 0; g < 9; g++) begin
      logic [7:0] one;
      one = 8'h01 << (g % 8);
      tick();
      chk($sformatf("rot_grant%0d", g), one, 1'b1, 1'b0);
      tick();
      chk($sformatf("rot_gap%0d", g), 8'h00, 1'b0, 1'b0);
    end
    bus.done = 1'b0;
    bus.req = 8'h00;
    tick();

    // Grant on 2 ignores req[5]; dropping req[2] hands over to 5.
    do_reset();
    bus.req = 8'h04;
    tick();
    chk("hold2", 8'h04, 1'b1, 1'b0);
    bus.req = 8'h24;
    tick();
    chk("hold2_ign5a", 8'h04, 1'b1, 1'b0);
    tick();
    chk("hold2_ign5b", 8'h04, 1'b1, 1'b0);
    bus.req = 8'h20;
    tick();
    chk("drop2", 8'h00, 1'b0, 1'b0);
    tick();
    chk("next5", 8'h20, 1'b1, 1'b0);
    bus.req = 8'h00;
    tick();

    // Async reset mid-grant, then arbitration restarts from ptr 0.
    do_reset();
    bus.req = 8'h40;
    tick();
    chk("grant6", 8'h40, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("async_reset", 8'h00, 1'b0, 1'b0);
    tick();
    bus.req = 8'h41;
    rst_n = 1'b1;
    tick();
    chk("after_reset_ptr0", 8'h01, 1'b1, 1'b0);
    bus.req = 8'h00;
    tick();

`ifdef RR_ARBITER8_TIMEOUT_EN
    do_reset();
    bus.req = 8'h08;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("to_hold%0d", c), 8'h08, 1'b1, 1'b0);
    end
    tick();
    chk("to_pulse", 8'h00, 1'b0, 1'b1);
    tick();
    chk("to_regrant", 8'h08, 1'b1, 1'b0);
    bus.req = 8'h00;
    tick();
`else
    do_reset();
    bus.req = 8'h10;
    tick();
    for (int c = 0; c < 300; c++) begin
      if (c % 50 == 0) chk($sformatf("long_hold%0d", c), 8'h10, 1'b1, 1'b0);
      tick();
    end
    chk("long_hold_end", 8'h10, 1'b1, 1'b0);
    bus.req = 8'h00;
    tick();
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rr_arbiter8.md
RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 The module SHALL have parameter MAX_HOLD, default 15: the maximum number of cycles a grant is held before forced release; legal range 1..255.
REQ-002 clk  input  1  rising-edge clock; the block's only clock.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req  input  8  request vector; bit i = requester i.
REQ-005 done  input  1  the current grantee releases its grant.
REQ-006 grant  output  8  one-hot grant, registered; grant[i]=1 means requester i owns the resource.
REQ-007 gnt_idx  output  3  binary index of the current or last grantee; grant is the 3-to-8 decode of gnt_idx whenever busy=1.
REQ-008 busy  output  1  high while in the GRANT state.
REQ-009 timeout  output  1  one-cycle pulse on a forced release.

Function
REQ-010 The FSM SHALL have two states: IDLE (grant=0, busy=0) and GRANT (grant one-hot, busy=1).
REQ-011 IDLE: if req!=0 at a clk edge, the FSM SHALL move to GRANT, with gnt_idx set to the first i with req[i]=1, searching ptr, ptr+1, ... mod 8.
REQ-012 IDLE with req=0: the FSM SHALL stay in IDLE, with ptr and gnt_idx unchanged.
REQ-013 Latency: grant SHALL become valid one cycle after req is sampled in IDLE.
REQ-014 GRANT SHALL be held while req[gnt_idx]=1, done=0 and no timeout occurs; changes on other req bits SHALL be ignored.
REQ-015 Release condition: done=1 or req[gnt_idx]=0 at a clk edge in GRANT. On release the FSM SHALL return to IDLE and grant SHALL clear after that edge.
REQ-016 On any release, ptr SHALL be set to (gnt_idx+1) mod 8, so index 7 wraps to 0.
REQ-017 After every release the FSM SHALL spend at least one IDLE cycle, so there are no back-to-back grants.
REQ-018 grant SHALL never have more than one bit set.
REQ-019 done asserted while in IDLE SHALL be ignored.
REQ-020 done=1 together with a timeout in the same cycle SHALL count as a normal release (timeout stays 0); the ptr update is the same.

Reset
REQ-021 While rst_n=0, outputs SHALL immediately be grant=0, gnt_idx=0, busy=0, timeout=0, with state=IDLE, ptr=0 and hold counter=0.
REQ-022 Reset asserted during GRANT SHALL drop grant asynchronously; the grant is not resumed after reset.
REQ-023 After rst_n deasserts, the first arbitration SHALL start from ptr=0.

Configuration
REQ-024 The macro RR_ARBITER8_TIMEOUT_EN SHALL control the timeout feature.
REQ-025 With RR_ARBITER8_TIMEOUT_EN defined, an 8-bit hold counter SHALL clear on entry to GRANT and increment on each GRANT cycle. When it equals MAX_HOLD-1 at an edge without done, the FSM SHALL force release to IDLE, pulse timeout for that one following cycle, and update ptr per REQ-016.
REQ-026 With RR_ARBITER8_TIMEOUT_EN undefined, there SHALL be no counter, timeout SHALL be tied to 0, and MAX_HOLD SHALL be unused; a grant is held until done or req drops.

Verification
REQ-027 Reset, then req=8'b0000_0001 -> one cycle later grant=8'h01, gnt_idx=0, busy=1; done pulse -> grant=0, busy=0 next cycle.
REQ-028 req=8'hFF held, done pulsed on every GRANT cycle -> grant sequence 01,02,04,...,80,01 with an idle gap of exactly one cycle between grants (wrap check).
REQ-029 Grant held on index 2 (grant=8'h04), then req[5] raised -> grant stays 8'h04; req[2] dropped -> release; next grant=8'h20.
REQ-030 TIMEOUT_EN defined, MAX_HOLD=4, req=8'h08 held, done=0 -> grant=8'h08 for exactly 4 cycles, then timeout=1 for 1 cycle with grant=0; next grant goes to index 3 again only if it is the sole requester.
REQ-031 rst_n pulled low mid-GRANT (grant=8'h40) -> grant=0 immediately, without waiting for clk; after release with req=8'h41 -> grant=8'h01 (ptr=0).
REQ-032 TIMEOUT_EN undefined, req=8'h10 held 300 cycles -> grant=8'h10 throughout, timeout stays 0.
